// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and encodings for the decode-stage hazard controller.
package hazard_pkg;

  // Forwarding mux selects seen by the decode stage.
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Next-PC source selects.
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_RET = 2'd3;

  // Register tags are held zero-extended to this width so the slot record
  // can live in the package; REG_BITS must not exceed it.
  localparam int SLOT_RD_W = 8;

  // One in-flight write tag in the shadow pipeline.
  typedef struct packed {
    logic                 v;
    logic [SLOT_RD_W-1:0] rd;
    logic                 regwr;
    logic                 memr;
  } slot_t;

  // A slot supplies source r when it is a live register write to r
  // (register 0 is excluded when it is hard-wired to zero).
  function automatic logic slot_match(input slot_t s, input logic [SLOT_RD_W-1:0] r,
                                      input logic r0_zero);
    return s.v && s.regwr && (s.rd == r) && !(r0_zero && (r == '0));
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage <-> hazard controller signal bundle.
interface id_hazard_ctrl_if #(
  parameter int REG_BITS = 3,
  parameter int CNT_W    = 16
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic                id_use1;
  logic                id_use2;
  logic [REG_BITS-1:0] id_rd;
  logic                id_regwr;
  logic                id_memr;
  logic                id_br;
  logic                id_jmp;
  logic                id_call;
  logic                id_ret;
  logic                comp_res;
  logic [1:0]          ForwardA;
  logic [1:0]          ForwardB;
  logic                stall;
  logic                kill;
  logic [1:0]          pc_sel;
  logic                RRWE;
  logic                JumpSrc;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    kill_cnt;

  // Decode side: presents the instruction, consumes the control decisions.
  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_regwr, id_memr,
           id_br, id_jmp, id_call, id_ret, comp_res,
    input  ForwardA, ForwardB, stall, kill, pc_sel, RRWE, JumpSrc, stall_cnt, kill_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_regwr, id_memr,
           id_br, id_jmp, id_call, id_ret, comp_res,
    output ForwardA, ForwardB, stall, kill, pc_sel, RRWE, JumpSrc, stall_cnt, kill_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl_fwd_select.sv
// Forward select and load-use detection for one source operand.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int R0_ZERO = 0
) (
  input  logic                 en,
  input  logic [SLOT_RD_W-1:0] src,
  input  slot_t                ex_s,
  input  slot_t                mem_s,
  input  slot_t                wb_s,
  output logic [1:0]           fwd,
  output logic                 load_hit
);

  logic r0z;
  assign r0z = (R0_ZERO != 0);

  // Youngest producer wins; a load still in EX has no data yet, so it
  // raises load_hit instead of selecting the EX path.
  always_comb begin
    fwd      = FWD_RF;
    load_hit = 1'b0;
    if (en) begin
      load_hit = slot_match(ex_s, src, r0z) && ex_s.memr;
      if (slot_match(ex_s, src, r0z) && !ex_s.memr) fwd = FWD_EX;
      else if (slot_match(mem_s, src, r0z))         fwd = FWD_MEM;
      else if (slot_match(wb_s, src, r0z))          fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard, forwarding and control-flow controller.
module id_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_BITS = 3,
  parameter int CNT_W    = 16,
  parameter int R0_ZERO  = 0
) (
  input logic             clk,
  input logic             rst_n,
  id_hazard_ctrl_if.slave bus
);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

  logic [SLOT_RD_W-1:0] src   [2];
  logic                 use_v [2];
  logic [1:0]           fwd   [2];
  logic                 hit   [2];
  logic                 stall;
  logic                 ctl_en;

  assign src[0]   = {{(SLOT_RD_W-REG_BITS){1'b0}}, bus.id_rs1};
  assign src[1]   = {{(SLOT_RD_W-REG_BITS){1'b0}}, bus.id_rs2};
  assign use_v[0] = bus.id_valid && bus.id_use1;
  assign use_v[1] = bus.id_valid && bus.id_use2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_select #(.R0_ZERO(R0_ZERO)) u_fwd (
      .en       (use_v[gi]),
      .src      (src[gi]),
      .ex_s     (ex_q),
      .mem_s    (mem_q),
      .wb_s     (wb_q),
      .fwd      (fwd[gi]),
      .load_hit (hit[gi])
    );
  end

  assign stall        = bus.id_valid && (hit[0] || hit[1]);
  assign bus.stall    = stall;
  assign bus.ForwardA = fwd[0];
  assign bus.ForwardB = fwd[1];

  // Control decisions wait out a stall (operands not ready) and are held
  // low while reset is asserted.
  assign ctl_en = rst_n && bus.id_valid && !stall;

  // Branch/jump/call/return resolution, ret > call > jmp > br.
  always_comb begin
    bus.kill    = 1'b0;
    bus.pc_sel  = PC_SEQ;
    bus.RRWE    = 1'b0;
    bus.JumpSrc = 1'b0;
    if (ctl_en) begin
      if (bus.id_ret) begin
        bus.kill    = 1'b1;
        bus.pc_sel  = PC_RET;
        bus.JumpSrc = 1'b1;
      end else if (bus.id_call) begin
        bus.kill   = 1'b1;
        bus.pc_sel = PC_JMP;
        bus.RRWE   = 1'b1;
      end else if (bus.id_jmp) begin
        bus.kill   = 1'b1;
        bus.pc_sel = PC_JMP;
      end else if (bus.id_br && bus.comp_res) begin
        bus.kill   = 1'b1;
        bus.pc_sel = PC_BR;
      end
    end
  end

  // Shadow pipeline advance and saturating event counters.
  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (bus.id_valid && !stall) begin
      ex_d.v     = 1'b1;
      ex_d.rd    = {{(SLOT_RD_W-REG_BITS){1'b0}}, bus.id_rd};
      ex_d.regwr = bus.id_regwr;
      ex_d.memr  = bus.id_memr;
    end
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (bus.kill && (kill_cnt_q != '1)) kill_cnt_d = kill_cnt_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.kill_cnt  = kill_cnt_q;

endmodule
